// File: rtl/multi_rect_object.sv
// Multi-channel rectangle renderer: priority hit-test over N_OBJ equally sized
// rectangles, registered pixel outputs, optional per-channel blink (MULTI_RECT_BLINK_EN).
module multi_rect_object #(
  parameter int N_OBJ           = 4,
  parameter int OBJECT_WIDTH_X  = 32,
  parameter int OBJECT_HEIGHT_Y = 32,
  parameter int BLINK_FRAMES    = 8,
  parameter int BLINK_TOGGLES   = 6,
  localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [10:0]           pixelX,
  input  logic [10:0]           pixelY,
  input  logic                  startOfFrame,
  input  logic [N_OBJ*11-1:0]   topLeftX,
  input  logic [N_OBJ*11-1:0]   topLeftY,
  input  logic [N_OBJ*8-1:0]    objColor,
  input  logic [N_OBJ-1:0]      objEnable,
  input  logic [N_OBJ-1:0]      blinkStart,
  output logic [10:0]           offsetX,
  output logic [10:0]           offsetY,
  output logic                  drawingRequest,
  output logic [7:0]            RGBout,
  output logic [IW-1:0]         objIndex,
  output logic [N_OBJ-1:0]      blinking
);

  localparam logic [7:0] TRANSPARENT = 8'hFF;

  logic [N_OBJ-1:0] w_hidden;
  logic [N_OBJ-1:0] w_blinking;

  // Span test done in 12 bits so a rectangle near column 2047 does not wrap to 0.
  function automatic logic in_span(input logic [10:0] p, input logic [10:0] org,
                                   input int unsigned len);
    logic [11:0] lim;
    lim = {1'b0, org} + 12'(len);
    return ({1'b0, p} >= {1'b0, org}) && ({1'b0, p} < lim);
  endfunction

`ifdef MULTI_RECT_BLINK_EN
  localparam int FW = (BLINK_FRAMES  > 1) ? $clog2(BLINK_FRAMES)  : 1;
  localparam int TW = (BLINK_TOGGLES > 1) ? $clog2(BLINK_TOGGLES) : 1;

  typedef enum logic {ST_IDLE, ST_BLINK} state_t;

  state_t           r_state      [N_OBJ];
  state_t           w_state_nxt  [N_OBJ];
  logic [FW-1:0]    r_frame_cnt  [N_OBJ];
  logic [FW-1:0]    w_frame_nxt  [N_OBJ];
  logic [TW-1:0]    r_toggle_cnt [N_OBJ];
  logic [TW-1:0]    w_toggle_nxt [N_OBJ];
  logic [N_OBJ-1:0] r_hidden;
  logic [N_OBJ-1:0] w_hidden_nxt;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < N_OBJ; i++) begin
        r_state[i]      <= ST_IDLE;
        r_frame_cnt[i]  <= '0;
        r_toggle_cnt[i] <= '0;
      end
      r_hidden <= '0;
    end else begin
      for (int i = 0; i < N_OBJ; i++) begin
        r_state[i]      <= w_state_nxt[i];
        r_frame_cnt[i]  <= w_frame_nxt[i];
        r_toggle_cnt[i] <= w_toggle_nxt[i];
      end
      r_hidden <= w_hidden_nxt;
    end
  end

  // Disable dominates, then a restart pulse, then frame-driven progress.
  always_comb begin
    for (int i = 0; i < N_OBJ; i++) begin
      w_state_nxt[i]  = r_state[i];
      w_frame_nxt[i]  = r_frame_cnt[i];
      w_toggle_nxt[i] = r_toggle_cnt[i];
      w_hidden_nxt[i] = r_hidden[i];
      if (!objEnable[i]) begin
        w_state_nxt[i]  = ST_IDLE;
        w_frame_nxt[i]  = '0;
        w_toggle_nxt[i] = '0;
        w_hidden_nxt[i] = 1'b0;
      end else if (blinkStart[i]) begin
        w_state_nxt[i]  = ST_BLINK;
        w_frame_nxt[i]  = '0;
        w_toggle_nxt[i] = '0;
        w_hidden_nxt[i] = 1'b0;
      end else begin
        case (r_state[i])
          ST_BLINK: begin
            if (startOfFrame) begin
              if (r_frame_cnt[i] == FW'(BLINK_FRAMES - 1)) begin
                w_frame_nxt[i] = '0;
                if (r_toggle_cnt[i] == TW'(BLINK_TOGGLES - 1)) begin
                  w_state_nxt[i]  = ST_IDLE;
                  w_toggle_nxt[i] = '0;
                  w_hidden_nxt[i] = 1'b0;
                end else begin
                  w_toggle_nxt[i] = r_toggle_cnt[i] + 1'b1;
                  w_hidden_nxt[i] = ~r_hidden[i];
                end
              end else begin
                w_frame_nxt[i] = r_frame_cnt[i] + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_OBJ; i++) w_blinking[i] = (r_state[i] == ST_BLINK);
  end
  assign w_hidden = r_hidden;
`else
  localparam int unused_blink_cfg = BLINK_FRAMES + BLINK_TOGGLES;
  logic w_unused_blink_in;
  assign w_unused_blink_in = ^{blinkStart, startOfFrame};
  assign w_hidden   = '0;
  assign w_blinking = '0;
`endif

  logic          w_found;
  logic [IW-1:0] w_win;
  logic [7:0]    w_color;
  logic [10:0]   w_offx;
  logic [10:0]   w_offy;

  // Scan from the highest index down so the lowest-index candidate is the one left standing.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_color = TRANSPARENT;
    w_offx  = '0;
    w_offy  = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (in_span(pixelX, topLeftX[i*11 +: 11], OBJECT_WIDTH_X) &&
          in_span(pixelY, topLeftY[i*11 +: 11], OBJECT_HEIGHT_Y) &&
          objEnable[i] && !w_hidden[i]) begin
        w_found = 1'b1;
        w_win   = IW'(i);
        w_color = objColor[i*8 +: 8];
        w_offx  = pixelX - topLeftX[i*11 +: 11];
        w_offy  = pixelY - topLeftY[i*11 +: 11];
      end
    end
  end

  logic          r_draw;
  logic [7:0]    r_rgb;
  logic [IW-1:0] r_idx;
  logic [10:0]   r_offx;
  logic [10:0]   r_offy;
  logic [N_OBJ-1:0] r_blinking;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_draw     <= 1'b0;
      r_rgb      <= 8'h00;
      r_idx      <= '0;
      r_offx     <= '0;
      r_offy     <= '0;
      r_blinking <= '0;
    end else begin
      r_draw     <= w_found;
      r_rgb      <= w_color;
      r_idx      <= w_win;
      r_offx     <= w_offx;
      r_offy     <= w_offy;
      r_blinking <= '0;
    end
  end

  assign drawingRequest = r_draw;
  assign RGBout         = r_rgb;
  assign objIndex       = r_idx;
  assign offsetX        = r_offx;
  assign offsetY        = r_offy;
  assign blinking       = w_blinking | r_blinking;

endmodule

// File: tb/tb_multi_rect_object.sv
// Randomised + directed bench for multi_rect_object; blink expectations follow
// MULTI_RECT_BLINK_EN when the same macro is defined for the bench.
module tb_multi_rect_object;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int BF = 2;
  localparam int BT = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            resetN = 1'b0;
  logic [10:0]     pixelX = '0, pixelY = '0;
  logic            startOfFrame = 1'b0;
  logic [N*11-1:0] topLeftX = '0, topLeftY = '0;
  logic [N*8-1:0]  objColor = '0;
  logic [N-1:0]    objEnable = '0, blinkStart = '0;
  logic [10:0]     offsetX, offsetY;
  logic            drawingRequest;
  logic [7:0]      RGBout;
  logic [IW-1:0]   objIndex;
  logic [N-1:0]    blinking;

  multi_rect_object #(.N_OBJ(N), .OBJECT_WIDTH_X(W), .OBJECT_HEIGHT_Y(H),
                      .BLINK_FRAMES(BF), .BLINK_TOGGLES(BT)) dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .objColor(objColor), .objEnable(objEnable), .blinkStart(blinkStart),
    .offsetX(offsetX), .offsetY(offsetY), .drawingRequest(drawingRequest),
    .RGBout(RGBout), .objIndex(objIndex), .blinking(blinking));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a channel in a blink sequence counts frames n since start;
  // it is hidden during odd half-periods and the sequence ends after BF*BT frames.
  logic [N-1:0] m_act = '0;
  int           m_n [N];
  logic [N-1:0] m_hid;
  logic [N-1:0] n_act;
  int           n_n [N];
  logic         n_dr, e_dr;
  logic [7:0]   n_rgb, e_rgb;
  logic [IW-1:0] n_idx, e_idx;
  logic [10:0]  n_ox, n_oy, e_ox, e_oy;
  bit           m_valid = 1'b0;

  initial for (int i = 0; i < N; i++) m_n[i] = 0;

  always_comb begin
    for (int i = 0; i < N; i++) m_hid[i] = m_act[i] && (((m_n[i] / BF) % 2) == 1);
  end

  always_comb begin
    bit found;
    found = 1'b0;
    n_dr = 1'b0; n_rgb = 8'hFF; n_idx = '0; n_ox = '0; n_oy = '0;
    for (int i = 0; i < N; i++) begin
      int x0, y0, px, py;
      x0 = int'(topLeftX[i*11 +: 11]); y0 = int'(topLeftY[i*11 +: 11]);
      px = int'(pixelX); py = int'(pixelY);
      if (!found && objEnable[i] && !m_hid[i] &&
          px >= x0 && px < x0 + W && py >= y0 && py < y0 + H) begin
        found = 1'b1;
        n_dr = 1'b1; n_rgb = objColor[i*8 +: 8]; n_idx = IW'(i);
        n_ox = 11'(px - x0); n_oy = 11'(py - y0);
      end
    end
    for (int i = 0; i < N; i++) begin
      n_act[i] = m_act[i];
      n_n[i]   = m_n[i];
`ifdef MULTI_RECT_BLINK_EN
      if (!objEnable[i]) begin
        n_act[i] = 1'b0; n_n[i] = 0;
      end else if (blinkStart[i]) begin
        n_act[i] = 1'b1; n_n[i] = 0;
      end else if (m_act[i] && startOfFrame) begin
        n_n[i] = m_n[i] + 1;
        if (n_n[i] == BF * BT) begin
          n_act[i] = 1'b0; n_n[i] = 0;
        end
      end
`endif
    end
  end

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (!resetN) begin
      e_dr <= 1'b0; e_rgb <= 8'h00; e_idx <= '0; e_ox <= '0; e_oy <= '0;
      m_act <= '0;
      for (int i = 0; i < N; i++) m_n[i] <= 0;
    end else begin
      e_dr <= n_dr; e_rgb <= n_rgb; e_idx <= n_idx; e_ox <= n_ox; e_oy <= n_oy;
      m_act <= n_act;
      for (int i = 0; i < N; i++) m_n[i] <= n_n[i];
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_dr", 32'(drawingRequest), 32'(e_dr));
      chk("model_rgb", 32'(RGBout), 32'(e_rgb));
      chk("model_idx", 32'(objIndex), 32'(e_idx));
      chk("model_offx", 32'(offsetX), 32'(e_ox));
      chk("model_offy", 32'(offsetY), 32'(e_oy));
      chk("model_blinking", 32'(blinking), 32'(m_act));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    pixelX = 11'(x); pixelY = 11'(y);
    tick();
  endtask

  task automatic sof();
    startOfFrame = 1'b1; tick();
    startOfFrame = 1'b0; tick();
  endtask

  task automatic place(input int ch, input int x, input int y, input logic [7:0] col);
    topLeftX[ch*11 +: 11] = 11'(x);
    topLeftY[ch*11 +: 11] = 11'(y);
    objColor[ch*8 +: 8]   = col;
  endtask

  initial begin
    resetN = 1'b0;
    tick(); tick();
    chk("reset_dr", 32'(drawingRequest), 32'd0);
    chk("reset_rgb", 32'(RGBout), 32'h00);
    chk("reset_idx", 32'(objIndex), 32'd0);
    chk("reset_blinking", 32'(blinking), 32'd0);

    place(0, 100, 100, 8'h1C);
    place(1, 2030, 0, 8'h03);
    place(2, 110, 110, 8'hE0);
    place(3, 600, 400, 8'h55);
    objEnable = 4'hF;
    resetN = 1'b1;

    pix(100, 100);
    chk("inside_dr", 32'(drawingRequest), 32'd1);
    chk("inside_offx", 32'(offsetX), 32'd0);
    chk("inside_offy", 32'(offsetY), 32'd0);
    pix(132, 100);
    chk("right_edge_dr", 32'(drawingRequest), 32'd0);
    chk("right_edge_rgb", 32'(RGBout), 32'hFF);

    pix(115, 115);
    chk("overlap_rgb", 32'(RGBout), 32'h1C);
    chk("overlap_idx", 32'(objIndex), 32'd0);
    objEnable[0] = 1'b0;
    tick();
    chk("expose_rgb", 32'(RGBout), 32'hE0);
    chk("expose_idx", 32'(objIndex), 32'd2);
    chk("expose_offx", 32'(offsetX), 32'd5);
    objEnable[0] = 1'b1;

    pix(2047, 5);
    chk("edge_dr", 32'(drawingRequest), 32'd1);
    chk("edge_offx", 32'(offsetX), 32'd17);
    chk("edge_idx", 32'(objIndex), 32'd1);
    pix(5, 5);
    chk("nowrap_dr", 32'(drawingRequest), 32'd0);

    pix(2040, 10);
    blinkStart[1] = 1'b1; tick(); blinkStart[1] = 1'b0;
`ifdef MULTI_RECT_BLINK_EN
    chk("blink_start", 32'(blinking[1]), 32'd1);
    sof(); sof();
    chk("blink_hidden2", 32'(drawingRequest), 32'd0);
    sof(); sof();
    chk("blink_visible4", 32'(drawingRequest), 32'd1);
    sof(); sof(); sof();
    chk("blink_hidden7", 32'(drawingRequest), 32'd0);
    chk("blink_active7", 32'(blinking[1]), 32'd1);
    sof();
    chk("blink_done8", 32'(blinking[1]), 32'd0);
    chk("blink_done8_dr", 32'(drawingRequest), 32'd1);

    blinkStart[1] = 1'b1; tick(); blinkStart[1] = 1'b0;
    sof(); sof(); sof();
    chk("restart_pre_hidden", 32'(drawingRequest), 32'd0);
    blinkStart[1] = 1'b1; startOfFrame = 1'b1; tick();
    blinkStart[1] = 1'b0; startOfFrame = 1'b0; tick();
    chk("restart_visible", 32'(drawingRequest), 32'd1);
    chk("restart_blinking", 32'(blinking[1]), 32'd1);
    sof();
    chk("restart_frame1", 32'(drawingRequest), 32'd1);
    sof();
    chk("restart_frame2", 32'(drawingRequest), 32'd0);
    resetN = 1'b0; tick();
    chk("midreset_dr", 32'(drawingRequest), 32'd0);
    chk("midreset_rgb", 32'(RGBout), 32'h00);
    chk("midreset_offx", 32'(offsetX), 32'd0);
    chk("midreset_blinking", 32'(blinking), 32'd0);
    resetN = 1'b1; tick();
    sof(); sof();
    chk("noresume_dr", 32'(drawingRequest), 32'd1);
    chk("noresume_blinking", 32'(blinking), 32'd0);
`else
    sof(); sof();
    chk("noblink_dr", 32'(drawingRequest), 32'd1);
    chk("noblink_blinking", 32'(blinking), 32'd0);
`endif

    for (int i = 0; i < N; i++)
      place(i, $urandom_range(0, 2047), $urandom_range(0, 2047), 8'($urandom));
    for (int c = 0; c < 4000; c++) begin
      int ch;
      resetN = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 63) == 0)
        place($urandom_range(0, N - 1), $urandom_range(0, 2047), $urandom_range(0, 2047),
              8'($urandom));
      if ($urandom_range(0, 49) == 0) objEnable = 4'($urandom_range(0, 15)) | 4'b0100;
      blinkStart   = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      startOfFrame = ($urandom_range(0, 4) == 0);
      ch = $urandom_range(0, N - 1);
      pixelX = topLeftX[ch*11 +: 11] + 11'($urandom_range(0, 40)) - 11'd4;
      pixelY = topLeftY[ch*11 +: 11] + 11'($urandom_range(0, 40)) - 11'd4;
      tick();
    end
    resetN = 1'b1; blinkStart = '0; startOfFrame = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
